// File: rtl/ysyx_2022040010_shift_pkg.sv
// Shared definitions for the iterative shifter: op codes, FSM states, defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   XLEN_DEF / SHW_DEF : default datapath width and shift-amount width
//   OP_SLL/OP_SRL/OP_SRA : one-hot operation select codes
//   state_e            : FSM state encoding shared by the top level
//   op_is_valid()      : true for exactly one of the three legal op codes
package ysyx_2022040010_shift_pkg;

  localparam int XLEN_DEF = 64;
  localparam int SHW_DEF  = 6;

  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Any code other than the three one-hot values is treated as invalid.
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/ysyx_2022040010_shift_stage.sv
// One conditional shift step by 2^k, left or right with a programmable fill bit.
// Latency: purely combinational.
// Backpressure: none; the parent sequences one step per cycle.
//
// Ports:
//   i_dat  : working value in
//   i_k    : stage index, the step shifts by 2^i_k positions
//   i_left : 1 = shift left (zero fill), 0 = shift right (fill with i_fill)
//   i_fill : bit shifted in from the top on a right shift
//   i_en   : 0 = pass i_dat through unchanged
//   o_dat  : working value out
module ysyx_2022040010_shift_stage
  import ysyx_2022040010_shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CW   = 3
) (
  input  logic [XLEN-1:0] i_dat,
  input  logic [CW-1:0]   i_k,
  input  logic            i_left,
  input  logic            i_fill,
  input  logic            i_en,
  output logic [XLEN-1:0] o_dat
);

  logic [XLEN-1:0] w_lsh;
  logic [XLEN-1:0] w_rsh;
  logic [XLEN-1:0] w_fill_mask;

  always_comb begin
    w_lsh       = i_dat << (1 << i_k);
    w_rsh       = i_dat >> (1 << i_k);
    // Ones in exactly the top 2^k positions vacated by the right shift.
    w_fill_mask = ~({XLEN{1'b1}} >> (1 << i_k));

    o_dat = i_dat;
    if (i_en) begin
      if (i_left) begin
        o_dat = w_lsh;
      end else begin
        o_dat = w_rsh | (i_fill ? w_fill_mask : {XLEN{1'b0}});
      end
    end
  end

endmodule

// File: rtl/ysyx_2022040010_shift_seq.sv
// Sequential barrel shifter (sll/srl/sra plus RV64 W-variants), one log2 stage per cycle.
// Latency: fixed SHW cycles from accept to out_valid, independent of shift amount.
// Backpressure: result held in DONE until out_ready; no new request is taken until then.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready only in IDLE)
//   src, shamt, op, word : operand, amount, one-hot op select, W-variant select
//   flush                : abandons any in-flight operation, back to IDLE
//   out_valid / out_ready: result handshake
//   result               : shifted value, valid while out_valid
//   busy                 : high whenever the FSM is not IDLE
module ysyx_2022040010_shift_seq
  import ysyx_2022040010_shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = SHW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src,
  input  logic [SHW-1:0]  shamt,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CW-1:0] LAST_STAGE = CW'(SHW - 1);
  // Bit 5 of the amount is meaningless for 32-bit W-variants.
  localparam logic [SHW-1:0] W_AMT_BIT = SHW'(32);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_work;
  logic [XLEN-1:0] r_result;
  logic [SHW-1:0]  r_shamt;
  logic [2:0]      r_op;
  logic            r_word;
  logic            r_fill;
  logic            r_out_vld;

  logic [XLEN-1:0] w_prep;
  logic [SHW-1:0]  w_shamt_in;
  logic            w_fill_in;
  logic            w_stage_en;
  logic [XLEN-1:0] w_stage_out;
  logic [XLEN-1:0] w_final;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_vld;
  assign result    = r_result;

  // Operand preparation at accept. For W-variants the right shifts work on a
  // 64-bit image of the low word so a full-width shift gives the 32-bit answer
  // in the low half; sll needs no preparation since only the low word survives.
  always_comb begin
    w_prep = src;
    if (word) begin
      if (op == OP_SRL) begin
        w_prep = {{(XLEN-32){1'b0}}, src[31:0]};
      end else if (op == OP_SRA) begin
        w_prep = {{(XLEN-32){src[31]}}, src[31:0]};
      end
    end
  end

  assign w_shamt_in = word ? (shamt & ~W_AMT_BIT) : shamt;
  // Fill is fixed for the whole run: the MSB of the prepared operand for sra,
  // zero otherwise. Repeated sra steps keep that MSB, so latching it once is safe.
  assign w_fill_in  = (op == OP_SRA) && w_prep[XLEN-1];

  // Invalid ops never shift; their result is forced to zero at the end anyway.
  assign w_stage_en = r_shamt[r_cnt] && op_is_valid(r_op);

  ysyx_2022040010_shift_stage #(
    .XLEN (XLEN),
    .CW   (CW)
  ) u_stage (
    .i_dat  (r_work),
    .i_k    (r_cnt),
    .i_left (r_op == OP_SLL),
    .i_fill (r_fill),
    .i_en   (w_stage_en),
    .o_dat  (w_stage_out)
  );

  // Value captured into result on the last RUN edge.
  always_comb begin
    w_final = w_stage_out;
    if (!op_is_valid(r_op)) begin
      w_final = {XLEN{1'b0}};
    end else if (r_word) begin
      w_final = {{(XLEN-32){w_stage_out[31]}}, w_stage_out[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_result  <= '0;
      r_shamt   <= '0;
      r_op      <= '0;
      r_word    <= 1'b0;
      r_fill    <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (flush) begin
      // Flush wins over both the request and the result handshake.
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_work  <= w_prep;
            r_shamt <= w_shamt_in;
            r_op    <= op;
            r_word  <= word;
            r_fill  <= w_fill_in;
          end
        end
        ST_RUN: begin
          r_work <= w_stage_out;
          if (r_cnt == LAST_STAGE) begin
            r_state   <= ST_DONE;
            r_out_vld <= 1'b1;
            r_result  <= w_final;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            r_out_vld <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_shift_seq.sv
// Self-checking bench for the sequential shifter: directed corner cases plus
// randomized requests scored against an arithmetic reference model.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_ysyx_2022040010_shift_seq;

  localparam logic [2:0] C_SLL = 3'b100;
  localparam logic [2:0] C_SRL = 3'b010;
  localparam logic [2:0] C_SRA = 3'b001;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src;
  logic [5:0]  shamt;
  logic [2:0]  op;
  logic        word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_2022040010_shift_seq #(
    .XLEN (64),
    .SHW  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src       (src),
    .shamt     (shamt),
    .op        (op),
    .word      (word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Reference: plain RV64 shift semantics.
  function automatic logic [63:0] ref_shift(input logic [2:0] o, input logic w,
                                            input logic [63:0] s, input logic [5:0] n);
    logic [63:0] a;
    logic [63:0] v;
    int amt;
    amt = w ? (int'(n) % 32) : int'(n);
    case (o)
      C_SLL: v = s << amt;
      C_SRL: begin
        a = w ? {32'h0, s[31:0]} : s;
        v = a >> amt;
      end
      C_SRA: begin
        a = w ? {{32{s[31]}}, s[31:0]} : s;
        v = $signed(a) >>> amt;
      end
      default: return 64'h0;
    endcase
    if (w) v = {{32{v[31]}}, v[31:0]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (DUT must be idle), measure latency, hold the result
  // for 'stall' cycles with out_ready low, then consume it.
  task automatic do_op(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] s, input logic [5:0] n,
                       input logic [63:0] exp, input int stall);
    int cyc;
    in_valid = 1'b1;
    op = o; word = w; src = s; shamt = n;
    tick();
    in_valid = 1'b0;
    // Scramble inputs so a design that fails to latch them is exposed.
    src = ~s; shamt = ~n; op = ~o; word = ~w;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, ":latency"}, 64'(cyc), 64'd6);
    check({tag, ":result"}, result, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, ":hold_vld"}, 64'(out_valid), 64'd1);
      check({tag, ":hold_res"}, result, exp);
      check({tag, ":hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ":consumed"}, 64'(out_valid), 64'd0);
    check({tag, ":idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [2:0]  r_o;
    logic        r_w;
    logic [63:0] r_s;
    logic [5:0]  r_n;

    rst = 1'b1; in_valid = 1'b0; src = '0; shamt = '0; op = '0;
    word = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("reset:in_ready", 64'(in_ready), 64'd1);
    check("reset:out_valid", 64'(out_valid), 64'd0);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:result", result, 64'h0);
    rst = 1'b0;
    tick();

    do_op("sll63", C_SLL, 1'b0, 64'h1, 6'd63, 64'h8000000000000000, 0);
    do_op("sra4", C_SRA, 1'b0, 64'h8000000000000000, 6'd4, 64'hF800000000000000, 0);
    do_op("srl4", C_SRL, 1'b0, 64'h8000000000000000, 6'd4, 64'h0800000000000000, 0);
    do_op("srlw31", C_SRL, 1'b1, 64'hFFFFFFFF80000000, 6'd31, 64'h1, 0);
    do_op("sraw31", C_SRA, 1'b1, 64'hFFFFFFFF80000000, 6'd31, 64'hFFFFFFFFFFFFFFFF, 0);
    do_op("sllw1", C_SLL, 1'b1, 64'h40000001, 6'd1, 64'hFFFFFFFF80000002, 0);
    do_op("sllw_amt5", C_SLL, 1'b1, 64'h3, 6'd33, 64'h6, 0);
    do_op("shamt0", C_SRL, 1'b0, 64'hDEADBEEF12345678, 6'd0, 64'hDEADBEEF12345678, 0);
    do_op("shamt0w", C_SRL, 1'b1, 64'h00000000F0000000, 6'd0, 64'hFFFFFFFFF0000000, 0);
    do_op("invalid", 3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFF, 6'd5, 64'h0, 0);
    do_op("backpressure", C_SRA, 1'b0, 64'h8000000000000123, 6'd8, 64'hFF80000000000001, 10);

    for (int it = 0; it < 150; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3) r_o = C_SLL;
      else if (sel < 6) r_o = C_SRL;
      else if (sel < 9) r_o = C_SRA;
      else begin
        r_o = 3'($urandom_range(0, 7));
        if (r_o == C_SLL || r_o == C_SRL || r_o == C_SRA) r_o = 3'b111;
      end
      r_w = 1'($urandom_range(0, 1));
      r_s = {$urandom, $urandom};
      r_n = 6'($urandom_range(0, 63));
      do_op("rand", r_o, r_w, r_s, r_n, ref_shift(r_o, r_w, r_s, r_n),
            int'($urandom_range(0, 3)));
    end

    // Flush at RUN stage 3: back to IDLE next edge, no result ever appears.
    in_valid = 1'b1; op = C_SLL; word = 1'b0; src = 64'h1; shamt = 6'd7;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("flush:busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush:busy", 64'(busy), 64'd0);
    check("flush:in_ready", 64'(in_ready), 64'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("flush:no_out_valid", 64'(seen), 64'd0);
    end
    do_op("after_flush", C_SLL, 1'b0, 64'hF, 6'd4, 64'hF0, 0);

    // Reset at RUN stage 2, with a request offered during reset.
    in_valid = 1'b1; op = C_SRL; word = 1'b0; src = 64'hFFFF; shamt = 6'd3;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rstrun:busy", 64'(busy), 64'd0);
    check("rstrun:out_valid", 64'(out_valid), 64'd0);
    check("rstrun:result", result, 64'h0);
    check("rstrun:in_ready", 64'(in_ready), 64'd1);
    tick();
    check("rstrun:not_accepted", 64'(busy), 64'd0);
    do_op("after_rst", C_SRA, 1'b1, 64'h0000000080000000, 6'd4, 64'hFFFFFFFFF8000000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
